// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the command record used by the bus master and the
// peripheral slave wrappers.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [2:0]  size;
  } ahb_cmd_t;

endpackage

// File: rtl/ahb_lite_cmd_master.sv
// Single-transfer AHB-Lite master: turns a valid/ready command stream into pipelined
// NONSEQ/SINGLE transfers and returns exactly one in-order response per command.
module ahb_lite_cmd_master
  import ahb_lite_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011,
  parameter logic [2:0] SIZE_MAX  = HSIZE_WORD
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [31:0] cmd_wdata,
  input  logic [2:0]  cmd_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic        hmastlock,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [31:0] hrdata,
  input  logic [1:0]  hresp
);

  ahb_cmd_t    r_ap;
  ahb_cmd_t    r_retry;
  logic        r_ap_valid;
  logic        r_dp_valid;
  logic        r_dp_write;
  logic        r_dp_rej;
  logic        r_retry_valid;
  logic        r_err_hold;
  logic [31:0] r_hwdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic w_ap_rej;
  logic w_ap_move;
  logic w_dp_done;
  logic w_dp_fail;
  logic w_err_first;
  logic w_retry_go;
  logic w_accept;

  // Oversized commands ride the pipeline as bubbles so their response stays in order.
  assign w_ap_rej    = r_ap.size > SIZE_MAX;
  assign w_ap_move   = r_ap_valid && hready;
  assign w_dp_done   = r_dp_valid && hready;
  assign w_dp_fail   = r_dp_rej || (hresp != HRESP_OKAY);
  assign w_err_first = r_dp_valid && !r_dp_rej && !hready && (hresp != HRESP_OKAY) &&
                       !r_err_hold;
  assign w_retry_go  = r_retry_valid && !r_err_hold && (!r_ap_valid || hready);
  assign cmd_ready   = !r_err_hold && !r_retry_valid && (!r_ap_valid || hready);
  assign w_accept    = cmd_valid && cmd_ready;

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      r_ap          <= '{addr: '0, write: 1'b0, wdata: '0, size: HSIZE_WORD};
      r_retry       <= '0;
      r_ap_valid    <= 1'b0;
      r_dp_valid    <= 1'b0;
      r_dp_write    <= 1'b0;
      r_dp_rej      <= 1'b0;
      r_retry_valid <= 1'b0;
      r_err_hold    <= 1'b0;
      r_hwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
    end else begin
      r_rsp_valid <= w_dp_done;
      r_rsp_err   <= w_dp_done && w_dp_fail;
      r_rsp_rdata <= (w_dp_done && !w_dp_fail && !r_dp_write) ? hrdata : '0;

      if (w_ap_move) begin
        r_dp_valid <= 1'b1;
        r_dp_write <= r_ap.write;
        r_dp_rej   <= w_ap_rej;
        if (r_ap.write && !w_ap_rej) begin
          r_hwdata <= r_ap.wdata;
        end
      end else if (w_dp_done) begin
        r_dp_valid <= 1'b0;
      end

      if (w_err_first) begin
        r_err_hold <= 1'b1;
      end else if (w_dp_done) begin
        r_err_hold <= 1'b0;
      end

      // First ERROR cycle cancels the overlapped address phase into the retry buffer.
      if (w_err_first && r_ap_valid) begin
        r_retry       <= r_ap;
        r_retry_valid <= 1'b1;
        r_ap_valid    <= 1'b0;
      end else if (w_retry_go) begin
        r_ap          <= r_retry;
        r_ap_valid    <= 1'b1;
        r_retry_valid <= 1'b0;
      end else if (w_accept) begin
        r_ap       <= '{addr: cmd_addr, write: cmd_write, wdata: cmd_wdata, size: cmd_size};
        r_ap_valid <= 1'b1;
      end else if (w_ap_move) begin
        r_ap_valid <= 1'b0;
      end
    end
  end

  assign htrans    = (r_ap_valid && !w_ap_rej) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr     = r_ap.addr;
  assign hwrite    = r_ap.write;
  assign hsize     = r_ap.size;
  assign hwdata    = r_hwdata;
  assign hburst    = HBURST_SINGLE;
  assign hprot     = HPROT_VAL;
  assign hmastlock = 1'b0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: doc/ahb_lite_cmd_master.md
Name: ahb_lite_cmd_master

Overview:
- Single-transfer AHB-Lite bus master: the initiator end of the AHB-Lite slave interface used by our peripheral wrappers (e.g. PWM FREQ at 0x0, DUTY at 0x4).
- Converts a valid/ready command stream (addr, write, wdata, size) into pipelined NONSEQ/SINGLE transfers and returns one in-order response per command.
- Sits between a test/control sequencer and the AHB interconnect.
- Handles wait states, the two-cycle ERROR response, and retry of the cancelled overlapped transfer.

Parameters:
- HPROT_VAL, 4'b0011: constant driven on hprot (non-cacheable, privileged, data).
- SIZE_MAX, 3'b010: largest legal hsize; a command above this is rejected locally.

Ports:
- HCLK  in  1  clock; all logic rising-edge.
- HRESETn  in  1  reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted on the edge where valid&&ready.
- cmd_addr  in  32  byte address.
- cmd_write  in  1  1=write, 0=read.
- cmd_wdata  in  32  write data.
- cmd_size  in  3  hsize encoding.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  32  read data (0 for writes and errors).
- rsp_err  out  1  slave ERROR or local size reject.
- haddr  out  32;  htrans  out  2;  hwrite  out  1;  hsize  out  3;  hburst  out  3 (tied SINGLE 3'b000);  hprot  out  4;  hmastlock  out  1 (tied 0);  hwdata  out  32.
- hready  in  1  bus ready.
- hrdata  in  32  read data.
- hresp  in  2  00=OKAY, 01=ERROR.

Behaviour:
- Clock and reset: one clock, HCLK; reset is asynchronous and active-high, on port HRESETn (HRESETn=1 resets).
- Reset values: htrans=IDLE, haddr=0, hwrite=0, hsize=3'b010, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Internal state at reset: both phase stages empty, retry buffer empty.
- Reset mid-transfer: the in-flight transfer is dropped and no response is produced.
- Pipeline: address-phase stage (AP) and data-phase stage (DP), each with a valid flag and a captured command.
- Acceptance: cmd_ready = !err_hold && !retry_valid && (!AP.valid || hready).
  - On accept, AP loads the command and drives htrans=NONSEQ, haddr, hwrite and hsize from the registers next cycle.
  - With no new command, htrans=IDLE.
- Address phase completes at an edge with AP.valid && hready: AP moves to DP. hwdata = DP.wdata throughout the data phase (writes); hwdata holds its previous value for reads.
- Data phase completes at an edge with DP.valid && hready && hresp=OKAY.
  - Next cycle: rsp_valid=1, rsp_err=0, rsp_rdata = read ? hrdata : 0.
- Zero-wait latency: accept at edge T0, address phase T0–T1, data phase T1–T2, rsp_valid in cycle T2–T3.
- Throughput: one command per cycle back-to-back.
- Wait states (hready=0): AP and DP hold; haddr, htrans, hwdata stable; cmd_ready=0 while AP is full.
- ERROR, cycle 1 (hready=0, hresp=ERROR):
  - Set err_hold.
  - If AP is valid, copy it to the retry buffer and drive htrans=IDLE next cycle (cancel).
- ERROR, cycle 2 (hready=1, hresp=ERROR): rsp_valid=1, rsp_err=1, rsp_rdata=0 next cycle; clear err_hold.
- Retry: the cancelled command reissues as NONSEQ in the cycle after err_hold clears, ahead of any new command.
- Error with an empty AP: no retry occurs.
- Local size reject: accepted command with cmd_size>SIZE_MAX.
  - No bus transfer is issued.
  - It is queued in order and responds with rsp_err=1 after all earlier responses, at the earliest the cycle after DP drains.
- Responses are strictly in command order; exactly one response per accepted command.
- hresp values 10/11 are treated as ERROR.
- Address alignment is not checked; haddr is passed as given.

Decomposition:
- Shared package ahb_lite_pkg, which the slave wrappers also use:
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10.
  - HRESP_OKAY=2'b00, HRESP_ERROR=2'b01.
  - HSIZE_BYTE/HALF/WORD.
  - HBURST_SINGLE=3'b000.
  - Command struct typedef {addr, write, wdata, size}.
- No sub-module: AP, DP and the retry buffer are small registers in one module.

Test Plan:
- Write 0x0000_0000 data 0x0000_03E8 then write 0x0000_0004 data 0x0000_0080, zero wait.
  - htrans NONSEQ in two consecutive cycles; hwdata=0x3E8 in the second cycle, 0x80 in the third.
  - Two rsp_valid pulses at accept+3 and accept+4, both rsp_err=0.
- Read 0x4 with hready=0 for 3 data-phase cycles, hrdata=0x80 on the completing cycle.
  - haddr and htrans held during the waits; rsp_rdata=0x80 one cycle after hready rises; cmd_ready=0 while AP is full.
- Write 0x0 then read 0x4; slave returns ERROR for the write.
  - Write response rsp_err=1.
  - The read is cancelled (htrans=IDLE), then reissued and completes OKAY with its own rdata; order is error first, then read data.
- cmd_size=3'b011 between two legal writes.
  - No bus transfer for it.
  - Three responses in order: OK, err=1, OK.
- Assert HRESETn=1 mid data phase of a write.
  - Outputs return to reset values immediately (asynchronously).
  - No rsp_valid; after release, a new read of 0x0 completes normally.
